// File: rtl/iap_sub_pipe.sv
// iap_sub_pipe: two-stage approximate subtractor d = a - b with valid/ready handshake and op counter.
// Define ISUB_SAT_EN to clamp results whose exact upper part borrows to zero and flag sat_o.
module iap_sub_pipe #(
    parameter int WIDTH = 16,
    parameter int LOWER = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] d_o,
    output logic             sat_o,
    output logic [15:0]      op_cnt_o
);
    localparam int UPPER = WIDTH - LOWER;

    logic             stall;
    logic             bg_any;
    logic [LOWER-1:0] lo_d;

    logic             v1_q;
    logic [UPPER-1:0] a_hi_q;
    logic [UPPER-1:0] b_hi_q;
    logic [LOWER-1:0] lo_q;

    logic [UPPER-1:0] hi_diff;
    logic [WIDTH-1:0] d_d;
    logic             sat_d;

    logic             v2_q;
    logic [WIDTH-1:0] d_q;
    logic             sat_q;
    logic [15:0]      cnt_q;

    assign stall      = v2_q & ~out_ready_i;
    assign in_ready_o = ~stall;

    // Any borrow generated at or above bit i (within the low part) forces d[i] to 1.
    always_comb begin
        lo_d              = '0;
        bg_any            = ~a_i[LOWER-1] & b_i[LOWER-1];
        lo_d[LOWER-1]     = a_i[LOWER-1] ^ b_i[LOWER-1];
        for (int i = LOWER - 2; i >= 0; i--) begin
            bg_any  = bg_any | (~a_i[i] & b_i[i]);
            lo_d[i] = bg_any ? 1'b1 : (a_i[i] ^ b_i[i]);
        end
    end

    always_comb begin
        hi_diff = a_hi_q - b_hi_q;
        d_d     = {hi_diff, lo_q};
        sat_d   = 1'b0;
`ifdef ISUB_SAT_EN
        if (a_hi_q < b_hi_q) begin
            d_d   = '0;
            sat_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v1_q   <= 1'b0;
            a_hi_q <= '0;
            b_hi_q <= '0;
            lo_q   <= '0;
            v2_q   <= 1'b0;
            d_q    <= '0;
            sat_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            // A stall freezes both stages, so bubbles stay where they are.
            if (!stall) begin
                v1_q <= in_valid_i;
                if (in_valid_i) begin
                    a_hi_q <= a_i[WIDTH-1:LOWER];
                    b_hi_q <= b_i[WIDTH-1:LOWER];
                    lo_q   <= lo_d;
                end
                v2_q <= v1_q;
                if (v1_q) begin
                    d_q   <= d_d;
                    sat_q <= sat_d;
                end
            end
            if (v2_q && out_ready_i) begin
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    assign out_valid_o = v2_q;
    assign d_o         = d_q;
    assign sat_o       = sat_q;
    assign op_cnt_o    = cnt_q;

endmodule

// File: tb/tb_iap_sub_pipe.sv
// Bench for iap_sub_pipe: directed vector table, stall/reset/wrap sequences and a randomized
// stream scored against an arithmetic reference model (honours ISUB_SAT_EN).
module tb_iap_sub_pipe;
    localparam int WIDTH   = 16;
    localparam int LOWER   = 12;
    localparam int LO_MASK = (1 << LOWER) - 1;
    localparam int HI_MASK = (1 << (WIDTH - LOWER)) - 1;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [15:0] a_i = '0;
    logic [15:0] b_i = '0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [15:0] d_o;
    logic        sat_o;
    logic [15:0] op_cnt_o;

    iap_sub_pipe #(.WIDTH(WIDTH), .LOWER(LOWER)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .a_i         (a_i),
        .b_i         (b_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .d_o         (d_o),
        .sat_o       (sat_o),
        .op_cnt_o    (op_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [16:0] exp_q[$];
    logic [15:0] exp_cnt = '0;
    int          n_deliv = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_d = '0;
    logic        prev_sat = 1'b0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] d;
        logic        sat;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: low bits are a^b, except every bit up to the highest borrow-generate
    // position (bit LOWER-1 excluded) reads 1; upper bits are an exact modular difference.
    function automatic logic [16:0] ref_sub(input logic [15:0] a, input logic [15:0] b);
        int bg, p, force_m, lo, hi;
        bg = int'(~a & b) & LO_MASK;
        p  = -1;
        for (int i = 0; i < LOWER; i++) if (bg[i]) p = i;
        force_m = (p >= 0) ? (((1 << (p + 1)) - 1) & ((1 << (LOWER - 1)) - 1)) : 0;
        lo = (int'(a ^ b) & LO_MASK) | force_m;
        hi = (int'(a >> LOWER) - int'(b >> LOWER)) & HI_MASK;
`ifdef ISUB_SAT_EN
        if ((a >> LOWER) < (b >> LOWER)) return {1'b1, 16'h0000};
`endif
        return {1'b0, 16'((hi << LOWER) | lo)};
    endfunction

    // One clock cycle: drive after the falling edge, sample 1 time unit later, score the
    // transfers that the next rising edge will perform.
    task automatic step(input logic iv, input logic [15:0] av, input logic [15:0] bv,
                        input logic ordy, output logic acc);
        logic [16:0] e;
        @(negedge clk_i);
        in_valid_i  = iv;
        a_i         = av;
        b_i         = bv;
        out_ready_i = ordy;
        #1;
        if (prev_stall) begin
            check("hold_d", d_o, prev_d);
            check("hold_sat", sat_o, prev_sat);
        end
        check("in_ready", in_ready_o, !(out_valid_o && !ordy));
        check("op_cnt", op_cnt_o, exp_cnt);
        if (out_valid_o && ordy) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("d", d_o, e[15:0]);
                check("sat", sat_o, e[16]);
            end
            exp_cnt++;
            n_deliv++;
        end
        acc = iv && in_ready_o;
        if (acc) exp_q.push_back(ref_sub(av, bv));
        prev_stall = out_valid_o && !ordy;
        prev_d     = d_o;
        prev_sat   = sat_o;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i       = 1'b1;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        exp_q.delete();
        exp_cnt    = '0;
        n_deliv    = 0;
        prev_stall = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("ready_after_rst", in_ready_o, 1);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) step(1'b0, '0, '0, 1'b1, acc);
        check("drained", exp_q.size(), 0);
    endtask

    initial begin
        logic        acc;
        logic [15:0] sa[4];
        logic [15:0] sb[4];
        int          k, cyc, stalls;
        int          sent;

        vecs[0] = '{16'h5000, 16'h2000, 16'h3000, 1'b0};
        vecs[1] = '{16'h0F0F, 16'h00F0, 16'h0FFF, 1'b0};
        vecs[2] = '{16'h0123, 16'h0123, 16'h0000, 1'b0};
`ifdef ISUB_SAT_EN
        vecs[3] = '{16'h1000, 16'h2000, 16'h0000, 1'b1};
`else
        vecs[3] = '{16'h1000, 16'h2000, 16'hF000, 1'b0};
`endif
        vecs[4] = '{16'hFFFF, 16'h0001, 16'hFFFE, 1'b0};
        vecs[5] = '{16'h0000, 16'h0FFF, 16'h0FFF, 1'b0};

        repeat (2) @(negedge clk_i);
        #1;
        check("rst_out_valid", out_valid_o, 0);
        check("rst_d", d_o, 0);
        check("rst_sat", sat_o, 0);
        check("rst_op_cnt", op_cnt_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("ready_after_rst", in_ready_o, 1);

        // Directed vectors, one at a time, with latency check.
        for (int v = 0; v < 6; v++) begin
            step(1'b1, vecs[v].a, vecs[v].b, 1'b1, acc);
            check("vec_accept", acc, 1);
            step(1'b0, '0, '0, 1'b1, acc);
            check("vec_not_early", out_valid_o, 0);
            step(1'b0, '0, '0, 1'b1, acc);
            check("vec_out_valid", out_valid_o, 1);
            check("vec_d", d_o, vecs[v].d);
            check("vec_sat", sat_o, vecs[v].sat);
            if (v == 0) begin
                step(1'b0, '0, '0, 1'b1, acc);
                check("vec_op_cnt_1", op_cnt_o, 1);
            end
        end

        // Four back-to-back ops with the consumer stalled for three cycles.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sa[i] = 16'($urandom);
            sb[i] = 16'($urandom);
        end
        k = 0; cyc = 0; stalls = 0;
        while (n_deliv < 4 && cyc < 40) begin
            step(k < 4, sa[k < 4 ? k : 0], sb[k < 4 ? k : 0], !(cyc >= 3 && cyc < 6), acc);
            if (out_valid_o && !out_ready_i && !in_ready_o) stalls++;
            if (acc) k++;
            cyc++;
        end
        check("stall_delivered", n_deliv, 4);
        check("stall_cycles", stalls, 3);
        step(1'b0, '0, '0, 1'b1, acc);
        check("stall_op_cnt", op_cnt_o, 4);

        // Randomized stream.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) rb = ra;
            step($urandom_range(0, 3) != 0, ra, rb, $urandom_range(0, 3) != 0, acc);
        end
        drain();

        // Asynchronous reset with two ops in flight and a stalled result at the output.
        step(1'b1, 16'h7777, 16'h1111, 1'b0, acc);
        step(1'b1, 16'h6666, 16'h2222, 1'b0, acc);
        step(1'b0, '0, '0, 1'b0, acc);
        check("pre_rst_out_valid", out_valid_o, 1);
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid_o, 0);
        check("async_rst_op_cnt", op_cnt_o, 0);
        check("async_rst_d", d_o, 0);
        exp_q.delete();
        exp_cnt = '0;
        prev_stall = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("ready_after_async_rst", in_ready_o, 1);
        for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b1, acc);
        check("no_stale_out", out_valid_o, 0);

        // Counter wrap after 65536 transfers.
        do_reset();
        sent = 0; cyc = 0;
        while (n_deliv < 65535 && cyc < 70000) begin
            step(sent < 65536, 16'($urandom), 16'($urandom), 1'b1, acc);
            if (acc) sent++;
            cyc++;
        end
        step(sent < 65536, 16'h4321, 16'h1234, 1'b0, acc);
        if (acc) sent++;
        check("op_cnt_ffff", op_cnt_o, 16'hFFFF);
        while (n_deliv < 65536 && cyc < 70010) begin
            step(sent < 65536, 16'($urandom), 16'($urandom), 1'b1, acc);
            if (acc) sent++;
            cyc++;
        end
        check("wrap_delivered", n_deliv, 65536);
        step(1'b0, '0, '0, 1'b1, acc);
        check("op_cnt_wrap", op_cnt_o, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
